dffq_bank_arbiter: RTL
======================

# dffq_bank_arbiter

Two-requester write arbiter and sequencer for a small register bank built from positive-edge DFFQ cells in the 9-track 5V library. Grants one write per clock to the bank using round-robin priority. A granted requester can lock the bank for a bounded burst. Provides a combinational read port, and sits between two register-programming masters and the shared configuration bank they both update.

## Interface
- WIDTH, 8, data bits per bank entry
- DEPTH, 4, number of entries; power of two, ≥2
- AW, log2(DEPTH), address width (derived)
- BURST_MAX, 4, maximum beats per locked ownership; ≥1 (1 disables locking)

Ports:
- CLK  in  1  single clock, all state updates on rising edge
- RN  in  1  reset, synchronous and active-low
- valid0  in  1  requester 0 write request
- addr0  in  AW  requester 0 write address
- data0  in  WIDTH  requester 0 write data
- lock0  in  1  requester 0 requests continued ownership after this beat
- ready0  out  1  requester 0 write accepted this cycle
- valid1, addr1, data1, lock1, ready1: same as requester 0, for requester 1
- rd_addr  in  AW  read address
- rd_data  out  WIDTH  bank[rd_addr], combinational
- owner  out  2  {locked, id}: bit1=1 while in OWN state, bit0=owning requester id

## Operation
- Transfer on requester x: validx & readyx at the rising CLK edge. Effect: bank[addrx] <= datax. At most one transfer per cycle.
- State: FSM {IDLE, OWN0, OWN1}, round-robin pointer rr (1 bit, favoured requester), beat counter cnt (clog2(BURST_MAX) bits, minimum 1).
- IDLE:
  - Only one valid: that requester gets ready.
  - Both valid: requester rr gets ready.
  - Neither valid: both ready 0.
- IDLE transfer by x:
  - If lockx=1 and BURST_MAX>1: go to OWNx, cnt=1.
  - Otherwise: stay IDLE, rr=1-x.
- OWNx:
  - readyx = validx; the other requester's ready = 0.
  - Transfer with lockx=1 and cnt<BURST_MAX-1: stay, cnt++.
  - Transfer with lockx=0, or cnt==BURST_MAX-1 (forced release after BURST_MAX total beats): go to IDLE, rr=1-x, cnt=0.
  - validx=0 for a cycle: release to IDLE, rr=1-x, cnt=0, no write.
- Reset (RN=0 at the edge): state=IDLE, rr=0, cnt=0, all bank entries=0. Reset wins over any concurrent transfer.
- While RN=0: ready0=ready1=0 combinationally.
- Reset output values: ready0=0, ready1=0, owner=2'b00, rd_data=0 for every rd_addr.
- owner in IDLE = 2'b00; in OWNx = {1,x}.
- Addresses use their full AW bits; no out-of-range case exists.
- Locking is ignored when BURST_MAX=1.

## Timing
- ready is combinational from state, rr, RN and valids only; it never depends on addr, data or lock. Requesters must not make valid depend on ready.
- Write latency: a transfer at edge N is visible on rd_data from after edge N.
- Read/write same address in the same cycle: rd_data shows the old value until the edge.
- Grant change latency: the other requester can be granted in the cycle immediately after a release edge.
- Burst: at most BURST_MAX consecutive transfers by one requester while the other is waiting.
- Fairness: with both requesters continuously valid and no lock, grants alternate every cycle.
- Starvation bound: BURST_MAX cycles.

## Test plan
- Reset: write 0xFF to all entries, then hold RN=0 for 2 cycles -> ready0=ready1=0, owner=00. After release, rd_data=0x00 at addr 0..3. With valid0=1, ready0=1 on the first cycle RN=1.
- Round-robin: valid0 and valid1 continuously, lock=0, addr0=0/data0=0xA5, addr1=1/data1=0x5A -> grants 0,1,0,1. bank[0]=0xA5, bank[1]=0x5A after cycle 2.
- Forced release: lock0=1 held, valid0 and valid1 continuously, BURST_MAX=4 -> ready0 for 4 cycles, owner=10 during cycles 2-4, ready1=0 throughout. Then IDLE and ready1=1 on cycle 5.
- Owner drop: enter OWN1 via lock1, then valid1=0 for one cycle while valid0=1 -> no write that cycle, IDLE next cycle, ready0=1, owner=00.
- Reset mid-burst: RN=0 at the edge of the 2nd locked beat by requester 0 -> that beat is not written, bank all 0, owner=00, rr=0.
- Read-during-write: rd_addr=2, transfer writing 0x3C to addr 2 -> rd_data shows the old value in that cycle and 0x3C the next cycle.

Source files
------------

// File: rtl/dffq_bank_arbiter.sv
// Two-requester round-robin write arbiter for a small DFFQ register bank.
// A granted requester may lock the bank for up to BURST_MAX beats; reads are combinational.
module dffq_bank_arbiter #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AW        = $clog2(DEPTH),
  parameter int BURST_MAX = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             valid0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] data0,
  input  logic             lock0,
  output logic             ready0,
  input  logic             valid1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] data1,
  input  logic             lock1,
  output logic             ready1,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       owner
);

  localparam int            CW       = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);
  localparam bit            LOCK_EN  = (BURST_MAX > 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_rr, w_rr_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_bank [DEPTH];
  logic             w_ready0, w_ready1;
  logic             w_xfer0, w_xfer1;

  // Handshake: a write happens on requester x when validx & readyx at the rising
  // edge. ready depends only on state, rr, RN and the valids, never on addr/data/lock.
  always_comb begin
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready0 = valid0 & (~valid1 | ~r_rr);
        w_ready1 = valid1 & (~valid0 | r_rr);
      end
      OWN0:    w_ready0 = valid0;
      OWN1:    w_ready1 = valid1;
      default: ;
    endcase
    if (!RN) begin
      w_ready0 = 1'b0;
      w_ready1 = 1'b0;
    end
  end

  assign ready0  = w_ready0;
  assign ready1  = w_ready1;
  assign w_xfer0 = valid0 & w_ready0;
  assign w_xfer1 = valid1 & w_ready1;

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_xfer0) begin
          if (lock0 && LOCK_EN) begin
            w_state_nxt = OWN0;
            w_cnt_nxt   = CW'(1);
          end else begin
            w_rr_nxt = 1'b1;
          end
        end else if (w_xfer1) begin
          if (lock1 && LOCK_EN) begin
            w_state_nxt = OWN1;
            w_cnt_nxt   = CW'(1);
          end else begin
            w_rr_nxt = 1'b0;
          end
        end
      end
      OWN0: begin
        // Owner leaves on a dropped valid, a dropped lock, or the burst limit.
        if (!valid0 || !lock0 || r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      OWN1: begin
        if (!valid1 || !lock1 || r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bank[i] <= '0;
      end
    end else if (w_xfer0) begin
      r_bank[addr0] <= data0;
    end else if (w_xfer1) begin
      r_bank[addr1] <= data1;
    end
  end

  assign rd_data = r_bank[rd_addr];
  assign owner   = {r_state != IDLE, r_state == OWN1};

endmodule
